// File: rtl/icap_stream_writer.sv
// AXI-Stream to ICAP write-port sequencer: gates on AVAIL, counts words, then waits for PRDONE/PRERROR/timeout.
// Optional build macro ICAP_BITSWAP_EN reverses the bit order inside each byte of every stream word.
module icap_stream_writer #(
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned TO_W        = 17
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        start,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        ICAP_CSIB,
  output logic [31:0] ICAP_I,
  output logic        ICAP_RDWRB,
  input  logic        ICAP_AVAIL,
  input  logic        ICAP_PRDONE,
  input  logic        ICAP_PRERROR,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] words_written
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_FLUSH,
    S_WAIT_PR,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_PRERR   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   word_in;
  logic                hs;
  logic                start_ok;
  logic                timeout_hit;

  logic                csib_q, csib_d;
  logic [DATA_W-1:0]   icap_i_q, icap_i_d;
  logic                rdwrb_q, rdwrb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   words_q, words_d;
  logic [TO_W-1:0]     to_q, to_d;

  function automatic logic is_busy(input state_t s);
    return (s == S_ARM) || (s == S_STREAM) || (s == S_FLUSH) || (s == S_WAIT_PR);
  endfunction

  // Byte-wise bit reversal for streams carrying .bin byte order
`ifdef ICAP_BITSWAP_EN
  for (genvar g = 0; g < 32; g++) begin : g_bitswap
    assign word_in[g] = s_axis_tdata[(g / 8) * 8 + 7 - (g % 8)];
  end
`else
  assign word_in = s_axis_tdata;
`endif

  // Ready depends only on state and AVAIL so the source never sees a tvalid loop
  assign s_axis_tready = (state_q == S_STREAM) && ICAP_AVAIL;
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign start_ok      = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign timeout_hit   = (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        if (ICAP_PRERROR)    state_d = S_ERR;
        else if (ICAP_AVAIL) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (ICAP_PRERROR)              state_d = S_ERR;
        else if (hs && s_axis_tlast)   state_d = S_FLUSH;
        else if (start)                state_d = S_ERR;
      end
      S_FLUSH: begin
        state_d = ICAP_PRERROR ? S_ERR : S_WAIT_PR;
      end
      S_WAIT_PR: begin
        if (ICAP_PRERROR)     state_d = S_ERR;
        else if (ICAP_PRDONE) state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; RDWRB stays low one extra cycle past the session
  always_comb begin
    csib_d   = 1'b1;
    icap_i_d = icap_i_q;
    rdwrb_d  = !(is_busy(state_q) || is_busy(state_d));
    busy_d   = is_busy(state_d);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERR);
    err_d    = err_q;
    words_d  = words_q;
    to_d     = to_q;

    if (start_ok) begin
      err_d   = ERR_NONE;
      words_d = '0;
      to_d    = '0;
    end

    if (hs) begin
      csib_d   = 1'b0;
      icap_i_d = word_in;
      words_d  = (words_q == '1) ? words_q : words_q + 32'd1;
    end

    if (state_q == S_WAIT_PR) begin
      to_d = to_q + TO_W'(1);
    end

    if ((state_d == S_ERR) && (state_q != S_ERR)) begin
      if (ICAP_PRERROR)              err_d = ERR_PRERR;
      else if (state_q == S_WAIT_PR) err_d = ERR_TIMEOUT;
      else                           err_d = ERR_ABORT;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      csib_q   <= 1'b1;
      icap_i_q <= '0;
      rdwrb_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= ERR_NONE;
      words_q  <= '0;
      to_q     <= '0;
    end else begin
      csib_q   <= csib_d;
      icap_i_q <= icap_i_d;
      rdwrb_q  <= rdwrb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      err_q    <= err_d;
      words_q  <= words_d;
      to_q     <= to_d;
    end
  end

  assign ICAP_CSIB     = csib_q;
  assign ICAP_I        = icap_i_q;
  assign ICAP_RDWRB    = rdwrb_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_icap_stream_writer.sv
// Self-checking bench for icap_stream_writer: directed scenarios plus randomized sessions against a transaction model.
module tb_icap_stream_writer;

  localparam int unsigned TO_CYC = 8;
`ifdef ICAP_BITSWAP_EN
  localparam logic [31:0] BS_EXP0 = 32'h000000FF;
  localparam logic [31:0] BS_EXP1 = 32'h00000080;
`else
  localparam logic [31:0] BS_EXP0 = 32'h000000FF;
  localparam logic [31:0] BS_EXP1 = 32'h00000001;
`endif

  logic        CLK = 1'b0;
  logic        RESETN = 1'b1;
  logic        start;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        ICAP_CSIB;
  logic [31:0] ICAP_I;
  logic        ICAP_RDWRB;
  logic        ICAP_AVAIL;
  logic        ICAP_PRDONE;
  logic        ICAP_PRERROR;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [31:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;

  icap_stream_writer #(.TIMEOUT_CYC(TO_CYC), .TO_W(4)) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .ICAP_CSIB(ICAP_CSIB), .ICAP_I(ICAP_I), .ICAP_RDWRB(ICAP_RDWRB),
    .ICAP_AVAIL(ICAP_AVAIL), .ICAP_PRDONE(ICAP_PRDONE), .ICAP_PRERROR(ICAP_PRERROR),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  // Expected ICAP word for a stream word, derived bit by bit
  function automatic logic [31:0] exp_word(input logic [31:0] d);
    logic [31:0] r;
`ifdef ICAP_BITSWAP_EN
    r = '0;
    for (int i = 0; i < 32; i++) r[(i / 8) * 8 + (7 - (i % 8))] = d[i];
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    ICAP_AVAIL = 1'b1; ICAP_PRDONE = 1'b0; ICAP_PRERROR = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    RESETN = 1'b0;
    #3;
    RESETN = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_in();
    #1 RESETN = 1'b0;
    #1;
    n_checks++; if (ICAP_CSIB !== 1'b1) begin n_fail++; $display("FAIL reset_csib got=%b exp=1", ICAP_CSIB); end
    n_checks++; if (ICAP_RDWRB !== 1'b1) begin n_fail++; $display("FAIL reset_rdwrb got=%b exp=1", ICAP_RDWRB); end
    n_checks++; if (ICAP_I !== 32'h0) begin n_fail++; $display("FAIL reset_i got=%h exp=0", ICAP_I); end
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got=%b exp=0", s_axis_tready); end
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, done, error}); end
    n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_errcode got=%0d exp=0", err_code); end
    n_checks++; if (words_written !== 32'd0) begin n_fail++; $display("FAIL reset_words got=%0d exp=0", words_written); end
    cyc(); cyc();
    RESETN = 1'b1;
    cyc();
    n_checks++; if (s_axis_tready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_quiet got tready=%b busy=%b exp=0,0", s_axis_tready, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    w[0] = 32'hAA995566; w[1] = 32'h20000000; w[2] = 32'h30008001;
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (busy !== 1'b1 || ICAP_RDWRB !== 1'b0 || ICAP_CSIB !== 1'b1) begin n_fail++; $display("FAIL arm_outputs got busy=%b rdwrb=%b csib=%b exp=1,0,1", busy, ICAP_RDWRB, ICAP_CSIB); end
    s_axis_tvalid = 1'b1; s_axis_tdata = w[0]; #1;
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL arm_tready got=%b exp=0", s_axis_tready); end
    cyc();
    for (int k = 0; k < 3; k++) begin
      s_axis_tdata = w[k]; s_axis_tlast = (k == 2); #1;
      n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL b2b_tready%0d got=%b exp=1", k, s_axis_tready); end
      cyc();
      n_checks++; if (ICAP_CSIB !== 1'b0) begin n_fail++; $display("FAIL b2b_csib%0d got=%b exp=0", k, ICAP_CSIB); end
      n_checks++; if (ICAP_I !== exp_word(w[k])) begin n_fail++; $display("FAIL b2b_i%0d got=%h exp=%h", k, ICAP_I, exp_word(w[k])); end
      n_checks++; if (words_written !== 32'(k + 1)) begin n_fail++; $display("FAIL b2b_words%0d got=%0d exp=%0d", k, words_written, k + 1); end
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cyc();
    n_checks++; if (ICAP_CSIB !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL waitpr_entry got csib=%b busy=%b exp=1,1", ICAP_CSIB, busy); end
    ICAP_PRDONE = 1'b1; cyc(); ICAP_PRDONE = 1'b0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || ICAP_RDWRB !== 1'b0) begin n_fail++; $display("FAIL done_entry got done=%b busy=%b rdwrb=%b exp=1,0,0", done, busy, ICAP_RDWRB); end
    cyc();
    n_checks++; if (ICAP_RDWRB !== 1'b1 || done !== 1'b1 || words_written !== 32'd3) begin n_fail++; $display("FAIL done_after got rdwrb=%b done=%b words=%0d exp=1,1,3", ICAP_RDWRB, done, words_written); end
  endtask

  task automatic test_bitswap();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    s_axis_tvalid = 1'b1; s_axis_tdata = 32'h000000FF; cyc();
    s_axis_tdata = 32'h00000001; s_axis_tlast = 1'b1;
    n_checks++; if (ICAP_I !== BS_EXP0) begin n_fail++; $display("FAIL bitswap_w0 got=%h exp=%h", ICAP_I, BS_EXP0); end
    cyc();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    n_checks++; if (ICAP_I !== BS_EXP1 || ICAP_CSIB !== 1'b0) begin n_fail++; $display("FAIL bitswap_w1 got=%h csib=%b exp=%h,0", ICAP_I, ICAP_CSIB, BS_EXP1); end
    cyc();
    ICAP_PRDONE = 1'b1; cyc(); ICAP_PRDONE = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bitswap_done got=%b exp=1", done); end
  endtask

  task automatic test_avail_gate();
    logic [31:0] w0, w1;
    w0 = $urandom(); w1 = $urandom();
    do_reset();
    ICAP_AVAIL = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = w0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (s_axis_tready !== 1'b0 || ICAP_CSIB !== 1'b1) begin n_fail++; $display("FAIL avail_hold%0d got tready=%b csib=%b exp=0,1", i, s_axis_tready, ICAP_CSIB); end
      cyc();
    end
    ICAP_AVAIL = 1'b1; cyc();
    #1;
    n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL avail_ready got=%b exp=1", s_axis_tready); end
    cyc();
    s_axis_tdata = w1; ICAP_AVAIL = 1'b0;
    n_checks++; if (ICAP_CSIB !== 1'b0 || ICAP_I !== exp_word(w0)) begin n_fail++; $display("FAIL avail_first got csib=%b i=%h exp=0,%h", ICAP_CSIB, ICAP_I, exp_word(w0)); end
    #1;
    n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL avail_drop_ready got=%b exp=0", s_axis_tready); end
    cyc();
    n_checks++; if (ICAP_CSIB !== 1'b1 || ICAP_I !== exp_word(w0)) begin n_fail++; $display("FAIL avail_hold_i got csib=%b i=%h exp=1,%h", ICAP_CSIB, ICAP_I, exp_word(w0)); end
    ICAP_AVAIL = 1'b1; cyc();
    n_checks++; if (ICAP_CSIB !== 1'b0 || ICAP_I !== exp_word(w1) || words_written !== 32'd2) begin n_fail++; $display("FAIL avail_resume got csib=%b i=%h words=%0d exp=0,%h,2", ICAP_CSIB, ICAP_I, words_written, exp_word(w1)); end
  endtask

  task automatic test_prerror();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = $urandom();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = w[0];
    cyc(); cyc();
    s_axis_tdata = w[1]; ICAP_PRERROR = 1'b1;
    cyc();
    ICAP_PRERROR = 1'b0; s_axis_tdata = w[2]; #1;
    n_checks++; if (error !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL prerr_status got error=%b code=%0d exp=1,1", error, err_code); end
    n_checks++; if (ICAP_CSIB !== 1'b0 || ICAP_I !== exp_word(w[1]) || words_written !== 32'd2) begin n_fail++; $display("FAIL prerr_lastword got csib=%b i=%h words=%0d exp=0,%h,2", ICAP_CSIB, ICAP_I, words_written, exp_word(w[1])); end
    n_checks++; if (s_axis_tready !== 1'b0 || ICAP_RDWRB !== 1'b0) begin n_fail++; $display("FAIL prerr_ready got tready=%b rdwrb=%b exp=0,0", s_axis_tready, ICAP_RDWRB); end
    cyc(); #1;
    n_checks++; if (ICAP_CSIB !== 1'b1 || ICAP_RDWRB !== 1'b1 || words_written !== 32'd2 || s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL prerr_after got csib=%b rdwrb=%b words=%0d tready=%b exp=1,1,2,0", ICAP_CSIB, ICAP_RDWRB, words_written, s_axis_tready); end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tdata = $urandom();
    cyc(); cyc();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cyc();
    for (int i = 0; i < int'(TO_CYC); i++) begin
      n_checks++; if (error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_wait%0d got error=%b busy=%b exp=0,1", i, error, busy); end
      cyc();
    end
    n_checks++; if (error !== 1'b1 || err_code !== 2'd2 || words_written !== 32'd1) begin n_fail++; $display("FAIL timeout_hit got error=%b code=%0d words=%0d exp=1,2,1", error, err_code, words_written); end
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (err_code !== 2'd0 || words_written !== 32'd0 || error !== 1'b0) begin n_fail++; $display("FAIL restart_clear got code=%0d words=%0d error=%b exp=0,0,0", err_code, words_written, error); end
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    cyc(); cyc();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cyc();
    ICAP_PRDONE = 1'b1; ICAP_PRERROR = 1'b1; cyc();
    ICAP_PRDONE = 1'b0; ICAP_PRERROR = 1'b0;
    n_checks++; if (error !== 1'b1 || done !== 1'b0 || err_code !== 2'd1) begin n_fail++; $display("FAIL both_pr got error=%b done=%b code=%0d exp=1,0,1", error, done, err_code); end
  endtask

  task automatic test_start_abort();
    do_reset();
    ICAP_AVAIL = 1'b0;
    start = 1'b1; cyc();
    cyc();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL arm_start_ignored got busy=%b error=%b exp=1,0", busy, error); end
    ICAP_AVAIL = 1'b1; cyc();
    s_axis_tvalid = 1'b1; s_axis_tdata = $urandom(); cyc();
    s_axis_tvalid = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || words_written !== 32'd1) begin n_fail++; $display("FAIL abort got error=%b code=%0d busy=%b words=%0d exp=1,3,0,1", error, err_code, busy, words_written); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = $urandom();
    cyc(); cyc();
    n_checks++; if (ICAP_CSIB !== 1'b0) begin n_fail++; $display("FAIL ares_pre got csib=%b exp=0", ICAP_CSIB); end
    #2 RESETN = 1'b0;
    #1;
    n_checks++; if (ICAP_CSIB !== 1'b1 || s_axis_tready !== 1'b0 || ICAP_RDWRB !== 1'b1) begin n_fail++; $display("FAIL ares_now got csib=%b tready=%b rdwrb=%b exp=1,0,1", ICAP_CSIB, s_axis_tready, ICAP_RDWRB); end
    n_checks++; if (words_written !== 32'd0 || busy !== 1'b0 || ICAP_I !== 32'd0) begin n_fail++; $display("FAIL ares_state got words=%0d busy=%b i=%h exp=0,0,0", words_written, busy, ICAP_I); end
    RESETN = 1'b1; s_axis_tvalid = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    n_checks++; if (words_written !== 32'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL ares_restart got words=%0d busy=%b exp=0,1", words_written, busy); end
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    cyc(); cyc();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    n_checks++; if (words_written !== 32'd1 || ICAP_CSIB !== 1'b0) begin n_fail++; $display("FAIL ares_count got words=%0d csib=%b exp=1,0", words_written, ICAP_CSIB); end
  endtask

  // Random words, tvalid gaps and AVAIL drops; expectations come from a word queue and the handshake rule
  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      logic [31:0] q[$];
      logic [31:0] last_d;
      int n, exp_words, budget, wait_cyc;
      bit waiting_arm, in_stream, prev_acc, prev_last, acc, exp_tready, flushed;
      do_reset();
      n = int'($urandom_range(20, 5));
      for (int i = 0; i < n; i++) q.push_back($urandom());
      exp_words = 0; waiting_arm = 1'b1; in_stream = 1'b0; prev_acc = 1'b0;
      prev_last = 1'b0; flushed = 1'b0; last_d = '0; budget = 500;
      start = 1'b1; cyc(); start = 1'b0;
      while (!flushed && budget > 0) begin
        n_checks++; if (ICAP_CSIB !== !prev_acc) begin n_fail++; $display("FAIL rnd%0d_csib got=%b exp=%b", s, ICAP_CSIB, !prev_acc); end
        if (prev_acc) begin
          n_checks++; if (ICAP_I !== exp_word(last_d) || words_written !== 32'(exp_words)) begin n_fail++; $display("FAIL rnd%0d_word got i=%h words=%0d exp=%h,%0d", s, ICAP_I, words_written, exp_word(last_d), exp_words); end
        end
        if (prev_acc && prev_last) flushed = 1'b1;
        ICAP_AVAIL    = ($urandom_range(99) < 75);
        s_axis_tvalid = !flushed && (q.size() > 0) && ($urandom_range(99) < 70);
        s_axis_tdata  = (q.size() > 0) ? q[0] : $urandom();
        s_axis_tlast  = (q.size() == 1);
        #1;
        exp_tready = in_stream && ICAP_AVAIL;
        n_checks++; if (s_axis_tready !== exp_tready) begin n_fail++; $display("FAIL rnd%0d_tready got=%b exp=%b", s, s_axis_tready, exp_tready); end
        acc = s_axis_tvalid && exp_tready;
        if (acc) begin last_d = q.pop_front(); exp_words++; end
        prev_last = acc && s_axis_tlast;
        if (prev_last) in_stream = 1'b0;
        if (waiting_arm && ICAP_AVAIL) begin waiting_arm = 1'b0; in_stream = 1'b1; end
        prev_acc = acc;
        cyc();
        budget--;
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      if (!flushed) begin
        n_checks++; n_fail++; $display("FAIL rnd%0d_budget got=expired exp=tlast accepted", s);
      end else begin
        wait_cyc = int'($urandom_range(5, 0));
        repeat (wait_cyc) begin
          n_checks++; if (busy !== 1'b1 || ICAP_CSIB !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_waitpr got busy=%b csib=%b exp=1,1", s, busy, ICAP_CSIB); end
          cyc();
        end
        ICAP_PRDONE = 1'b1; cyc(); ICAP_PRDONE = 1'b0;
        n_checks++; if (done !== 1'b1 || error !== 1'b0 || words_written !== 32'(n)) begin n_fail++; $display("FAIL rnd%0d_done got done=%b error=%b words=%0d exp=1,0,%0d", s, done, error, words_written, n); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_bitswap();
    test_avail_gate();
    test_prerror();
    test_timeout();
    test_start_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
